// File: rtl/framebuffer_scanout_pkg.sv
// Shared display-timing definitions for framebuffer clients.
// Holds the default pixel width, a 640x480 timing preset and helpers that
// derive line/frame totals and sync window edges from porch/pulse widths.
package framebuffer_scanout_pkg;

  // Word width shared with the framebuffer memory itself.
  localparam int PIXEL_WIDTH_DEFAULT = 9;

  function automatic int timing_total(input int act, input int fp, input int sy, input int bp);
    return act + fp + sy + bp;
  endfunction

  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_end(input int act, input int fp, input int sy);
    return act + fp + sy;
  endfunction

  // Standard 640x480 preset.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  localparam int VGA_H_TOTAL      = timing_total(VGA_H_ACTIVE, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  localparam int VGA_V_TOTAL      = timing_total(VGA_V_ACTIVE, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);
  localparam int VGA_HSYNC_START  = sync_start(VGA_H_ACTIVE, VGA_H_FRONT);
  localparam int VGA_HSYNC_END    = sync_end(VGA_H_ACTIVE, VGA_H_FRONT, VGA_H_SYNC);
  localparam int VGA_VSYNC_START  = sync_start(VGA_V_ACTIVE, VGA_V_FRONT);
  localparam int VGA_VSYNC_END    = sync_end(VGA_V_ACTIVE, VGA_V_FRONT, VGA_V_SYNC);

  // Per-pixel region flags carried down the alignment pipeline.
  // Sync flags are kept in asserted-sense; polarity is applied at the output.
  typedef struct packed {
    logic image;
    logic visible;
    logic hsync;
    logic vsync;
    logic frameStart;
  } scan_flags_t;

endpackage

// File: rtl/framebuffer_scanout_video_timing.sv
// Purpose: raster counters (hCount/vCount) plus visible/sync/line/frame decode.
// Latency: counters registered; all decode outputs are combinational from the counters.
// Backpressure: none; counters advance only on clk edges with i_pixelEnable=1, else hold.
// Ports: i_clk, i_reset (async, active-high), i_pixelEnable; o_hCount/o_vCount counters;
//        o_visible, o_hsync/o_vsync (asserted-sense), o_lineStart, o_lineEnd,
//        o_frameStart, o_frameEnd (o_frameEnd implies o_lineEnd).
module framebuffer_scanout_video_timing
  import framebuffer_scanout_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter int HC_WIDTH = $clog2(timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK) + 1),
  parameter int VC_WIDTH = $clog2(timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK) + 1)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_pixelEnable,
  output logic [HC_WIDTH-1:0] o_hCount,
  output logic [VC_WIDTH-1:0] o_vCount,
  output logic                o_visible,
  output logic                o_hsync,
  output logic                o_vsync,
  output logic                o_lineStart,
  output logic                o_lineEnd,
  output logic                o_frameStart,
  output logic                o_frameEnd
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [HC_WIDTH-1:0] H_LAST   = HC_WIDTH'(H_TOTAL - 1);
  localparam logic [VC_WIDTH-1:0] V_LAST   = VC_WIDTH'(V_TOTAL - 1);
  localparam logic [HC_WIDTH-1:0] H_VIS    = HC_WIDTH'(H_ACTIVE);
  localparam logic [VC_WIDTH-1:0] V_VIS    = VC_WIDTH'(V_ACTIVE);
  localparam logic [HC_WIDTH-1:0] HS_START = HC_WIDTH'(sync_start(H_ACTIVE, H_FRONT));
  localparam logic [HC_WIDTH-1:0] HS_END   = HC_WIDTH'(sync_end(H_ACTIVE, H_FRONT, H_SYNC));
  localparam logic [VC_WIDTH-1:0] VS_START = VC_WIDTH'(sync_start(V_ACTIVE, V_FRONT));
  localparam logic [VC_WIDTH-1:0] VS_END   = VC_WIDTH'(sync_end(V_ACTIVE, V_FRONT, V_SYNC));

  logic [HC_WIDTH-1:0] r_hCount;
  logic [VC_WIDTH-1:0] r_vCount;
  logic                w_lineEnd;
  logic                w_frameEnd;

  assign w_lineEnd  = (r_hCount == H_LAST);
  assign w_frameEnd = w_lineEnd && (r_vCount == V_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hCount <= '0;
      r_vCount <= '0;
    end else if (i_pixelEnable) begin
      if (w_lineEnd) begin
        r_hCount <= '0;
        r_vCount <= w_frameEnd ? '0 : r_vCount + 1'b1;
      end else begin
        r_hCount <= r_hCount + 1'b1;
      end
    end
  end

  assign o_hCount     = r_hCount;
  assign o_vCount     = r_vCount;
  assign o_visible    = (r_hCount < H_VIS) && (r_vCount < V_VIS);
  assign o_hsync      = (r_hCount >= HS_START) && (r_hCount < HS_END);
  assign o_vsync      = (r_vCount >= VS_START) && (r_vCount < VS_END);
  assign o_lineStart  = (r_hCount == '0);
  assign o_lineEnd    = w_lineEnd;
  assign o_frameStart = (r_hCount == '0) && (r_vCount == '0);
  assign o_frameEnd   = w_frameEnd;

endmodule

// File: rtl/framebuffer_scanout.sv
// Purpose: framebuffer read-side scanout; raster address walk with SCALE x SCALE replication.
// Latency: 3 enabled clks from counter position to pixelOut/active/hsync/vsync/frameStart.
// Backpressure: none; pixelEnable=0 freezes the pipeline, a read-data hold copy keeps any enable pattern exact.
// Ports: clk, reset (async, active-high), pixelEnable; fbAddress/fbWriteEnable/fbDataIn/fbDataOut
//        to framebuffer port B (read only, 1-clk read latency); pixelOut, hsync, vsync, active, frameStart.
module framebuffer_scanout
  import framebuffer_scanout_pkg::*;
#(
  parameter int PIXEL_WIDTH   = PIXEL_WIDTH_DEFAULT,
  parameter int FB_COLUMNS    = 64,
  parameter int FB_ROWS       = 32,
  parameter int SCALE         = 1,
  parameter int H_ACTIVE      = VGA_H_ACTIVE,
  parameter int H_FRONT       = VGA_H_FRONT,
  parameter int H_SYNC        = VGA_H_SYNC,
  parameter int H_BACK        = VGA_H_BACK,
  parameter int V_ACTIVE      = VGA_V_ACTIVE,
  parameter int V_FRONT       = VGA_V_FRONT,
  parameter int V_SYNC        = VGA_V_SYNC,
  parameter int V_BACK        = VGA_V_BACK,
  parameter int SYNC_POLARITY = 0,
  parameter int ADDR_WIDTH    = $clog2(FB_COLUMNS * FB_ROWS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixelEnable,
  output logic [ADDR_WIDTH-1:0]  fbAddress,
  output logic                   fbWriteEnable,
  output logic [PIXEL_WIDTH-1:0] fbDataIn,
  input  logic [PIXEL_WIDTH-1:0] fbDataOut,
  output logic [PIXEL_WIDTH-1:0] pixelOut,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   active,
  output logic                   frameStart
);

  localparam int HC_WIDTH = $clog2(timing_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK) + 1);
  localparam int VC_WIDTH = $clog2(timing_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK) + 1);
  localparam int SUB_W    = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HC_WIDTH-1:0]   IMG_W         = HC_WIDTH'(FB_COLUMNS * SCALE);
  localparam logic [VC_WIDTH-1:0]   IMG_H         = VC_WIDTH'(FB_ROWS * SCALE);
  localparam logic [SUB_W-1:0]      SUB_LAST      = SUB_W'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST      = ADDR_WIDTH'(FB_COLUMNS - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP      = ADDR_WIDTH'(FB_COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW_BASE = ADDR_WIDTH'((FB_ROWS - 1) * FB_COLUMNS);
  localparam logic                  SYNC_ACT      = (SYNC_POLARITY != 0);

  // Timing stage
  logic [HC_WIDTH-1:0] w_hCount;
  logic [VC_WIDTH-1:0] w_vCount;
  logic                w_visible;
  logic                w_hsAct;
  logic                w_vsAct;
  logic                w_unused_lineStart;
  logic                w_lineEnd;
  logic                w_frameStart;
  logic                w_frameEnd;

  framebuffer_scanout_video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .HC_WIDTH (HC_WIDTH),
    .VC_WIDTH (VC_WIDTH)
  ) u_video_timing (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_pixelEnable (pixelEnable),
    .o_hCount      (w_hCount),
    .o_vCount      (w_vCount),
    .o_visible     (w_visible),
    .o_hsync       (w_hsAct),
    .o_vsync       (w_vsAct),
    .o_lineStart   (w_unused_lineStart),
    .o_lineEnd     (w_lineEnd),
    .o_frameStart  (w_frameStart),
    .o_frameEnd    (w_frameEnd)
  );

  logic        w_imgH;
  logic        w_imgV;
  logic        w_image;
  scan_flags_t w_flags;

  assign w_imgH  = (w_hCount < IMG_W);
  assign w_imgV  = (w_vCount < IMG_H);
  assign w_image = w_imgH && w_imgV;
  assign w_flags = '{image: w_image, visible: w_visible, hsync: w_hsAct,
                     vsync: w_vsAct, frameStart: w_frameStart};

  // Address walk. r_col/r_rowBase always describe the current counter
  // position, so the address register needs only one adder, no multiplier.
  logic [ADDR_WIDTH-1:0] r_col;
  logic [SUB_W-1:0]      r_colSub;
  logic [ADDR_WIDTH-1:0] r_rowBase;
  logic [SUB_W-1:0]      r_rowSub;
  logic [ADDR_WIDTH-1:0] r_fbAddress;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col       <= '0;
      r_colSub    <= '0;
      r_rowBase   <= '0;
      r_rowSub    <= '0;
      r_fbAddress <= '0;
    end else if (pixelEnable) begin
      // Column: the next position is either a new line (restart) or one pixel on.
      if (w_lineEnd) begin
        r_col    <= '0;
        r_colSub <= '0;
      end else if (w_imgH) begin
        if (r_colSub == SUB_LAST) begin
          r_colSub <= '0;
          // Saturate on the last column so the trailing replica never overflows.
          if (r_col != COL_LAST) r_col <= r_col + 1'b1;
        end else begin
          r_colSub <= r_colSub + 1'b1;
        end
      end

      // Row: advances once per line while inside the image rows.
      if (w_frameEnd) begin
        r_rowBase <= '0;
        r_rowSub  <= '0;
      end else if (w_lineEnd && w_imgV) begin
        if (r_rowSub == SUB_LAST) begin
          r_rowSub <= '0;
          // Never step past the last framebuffer row.
          if (r_rowBase != LAST_ROW_BASE) r_rowBase <= r_rowBase + ROW_STEP;
        end else begin
          r_rowSub <= r_rowSub + 1'b1;
        end
      end

      // Outside the image the address holds, so port B keeps returning stable data.
      if (w_image) r_fbAddress <= r_rowBase + r_col;
    end
  end

  // Alignment pipeline: stage 1 alongside the address, stage 2 alongside read data.
  scan_flags_t r_flags1;
  scan_flags_t r_flags2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags1 <= '0;
      r_flags2 <= '0;
    end else if (pixelEnable) begin
      r_flags1 <= w_flags;
      r_flags2 <= r_flags1;
    end
  end

  // Read-data hold. Port B returns data for the address seen on the previous
  // clk. If stage 3 fires right after the stage-2 edge, that live data is the
  // wanted word; otherwise the word was captured one clk after the stage-2 edge
  // and must be replayed from the hold copy, since the address has moved on.
  logic                   r_enD1;
  logic [PIXEL_WIDTH-1:0] r_fbHold;
  logic [PIXEL_WIDTH-1:0] w_rdData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enD1   <= 1'b0;
      r_fbHold <= '0;
    end else begin
      r_enD1 <= pixelEnable;
      if (r_enD1) r_fbHold <= fbDataOut;
    end
  end

  assign w_rdData = r_enD1 ? fbDataOut : r_fbHold;

  // Stage 3: registered outputs.
  logic [PIXEL_WIDTH-1:0] r_pixelOut;
  logic                   r_active;
  logic                   r_hsync;
  logic                   r_vsync;
  logic                   r_frameStart;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pixelOut   <= '0;
      r_active     <= 1'b0;
      r_hsync      <= ~SYNC_ACT;
      r_vsync      <= ~SYNC_ACT;
      r_frameStart <= 1'b0;
    end else if (pixelEnable) begin
      r_pixelOut   <= r_flags2.image ? w_rdData : '0;
      r_active     <= r_flags2.visible;
      r_hsync      <= r_flags2.hsync ? SYNC_ACT : ~SYNC_ACT;
      r_vsync      <= r_flags2.vsync ? SYNC_ACT : ~SYNC_ACT;
      r_frameStart <= r_flags2.frameStart;
    end
  end

  assign fbAddress     = r_fbAddress;
  assign fbWriteEnable = 1'b0;
  assign fbDataIn      = '0;
  assign pixelOut      = r_pixelOut;
  assign active        = r_active;
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign frameStart    = r_frameStart;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: small 4x2 framebuffer, 14x9 raster, two
// instances (SCALE=2 and SCALE=1) sharing clk/reset/pixelEnable, each with a
// 1-clk read RAM. Expected outputs come from raster position arithmetic.
module tb_framebuffer_scanout;

  localparam int PW    = 9;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int AW    = 3;
  localparam int H_TOT = 14;
  localparam int V_TOT = 9;
  localparam int FRAME = H_TOT * V_TOT;

  logic clk = 1'b0;
  logic reset;
  logic pixelEnable;

  logic [AW-1:0] addr0, addr1;
  logic          we0, we1;
  logic [PW-1:0] din0, din1, dout0, dout1, pix0, pix1;
  logic          hs0, hs1, vs0, vs1, act0, act1, fs0, fs1;

  logic [PW-1:0] mem [COLS*ROWS];

  int checks   = 0;
  int failures = 0;
  int n        = 0;   // enabled edges since reset release

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dout0 <= mem[addr0];
    dout1 <= mem[addr1];
  end

  framebuffer_scanout #(
    .PIXEL_WIDTH(PW), .FB_COLUMNS(COLS), .FB_ROWS(ROWS), .SCALE(2),
    .H_ACTIVE(10), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POLARITY(0), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .pixelEnable(pixelEnable),
    .fbAddress(addr0), .fbWriteEnable(we0), .fbDataIn(din0), .fbDataOut(dout0),
    .pixelOut(pix0), .hsync(hs0), .vsync(vs0), .active(act0), .frameStart(fs0)
  );

  framebuffer_scanout #(
    .PIXEL_WIDTH(PW), .FB_COLUMNS(COLS), .FB_ROWS(ROWS), .SCALE(1),
    .H_ACTIVE(10), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POLARITY(0), .ADDR_WIDTH(AW)
  ) dut_s1 (
    .clk(clk), .reset(reset), .pixelEnable(pixelEnable),
    .fbAddress(addr1), .fbWriteEnable(we1), .fbDataIn(din1), .fbDataOut(dout1),
    .pixelOut(pix1), .hsync(hs1), .vsync(vs1), .active(act1), .frameStart(fs1)
  );

  typedef struct packed {
    logic [PW-1:0] pix;
    logic          act;
    logic          hs;
    logic          vs;
    logic          fs;
    logic [AW-1:0] addr;
  } exp_t;

  // Outputs after cnt enabled edges show raster position cnt-3; the address
  // register was last loaded from position cnt-1 (held outside the image).
  function automatic exp_t model(input int cnt, input int s);
    exp_t e;
    int p, h, v;
    e.pix = '0; e.act = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.fs = 1'b0; e.addr = '0;
    if (cnt >= 3) begin
      p = (cnt - 3) % FRAME;
      h = p % H_TOT;
      v = p / H_TOT;
      e.act = (h < 10) && (v < 6);
      e.hs  = !((h >= 11) && (h < 13));
      e.vs  = (v != 7);
      e.fs  = (p == 0);
      if (h < COLS * s && v < ROWS * s) e.pix = mem[(v / s) * COLS + h / s];
    end
    if (cnt >= 1) begin
      p = (cnt - 1) % FRAME;
      h = p % H_TOT;
      v = p / H_TOT;
      if (v >= ROWS * s)      e.addr = AW'(ROWS * COLS - 1);
      else if (h >= COLS * s) e.addr = AW'((v / s) * COLS + COLS - 1);
      else                    e.addr = AW'((v / s) * COLS + h / s);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at n=%0d t=%0t: got=0x%0h expected=0x%0h", tag, n, $time, got, exp);
    end
  endtask

  task automatic check_all();
    exp_t e0, e1;
    e0 = model(n, 2);
    e1 = model(n, 1);
    chk("s2_pixelOut",   32'(pix0),  32'(e0.pix));
    chk("s2_active",     32'(act0),  32'(e0.act));
    chk("s2_hsync",      32'(hs0),   32'(e0.hs));
    chk("s2_vsync",      32'(vs0),   32'(e0.vs));
    chk("s2_frameStart", 32'(fs0),   32'(e0.fs));
    chk("s2_fbAddress",  32'(addr0), 32'(e0.addr));
    chk("s1_pixelOut",   32'(pix1),  32'(e1.pix));
    chk("s1_active",     32'(act1),  32'(e1.act));
    chk("s1_hsync",      32'(hs1),   32'(e1.hs));
    chk("s1_vsync",      32'(vs1),   32'(e1.vs));
    chk("s1_frameStart", 32'(fs1),   32'(e1.fs));
    chk("s1_fbAddress",  32'(addr1), 32'(e1.addr));
    chk("fb_write_tie",  32'({we0, we1}), 32'd0);
    chk("fb_datain_tie", 32'(din0 | din1), 32'd0);
  endtask

  task automatic step(input logic en);
    pixelEnable = en;
    @(posedge clk);
    if (en && !reset) n++;
    #1;
    check_all();
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b1;
    n     = 0;
    #1;
    check_all();   // asynchronous: no clk edge has occurred yet
    for (int i = 0; i < COLS * ROWS; i++) mem[i] = PW'($urandom);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < COLS * ROWS; i++) mem[i] = PW'(32'h100 | i);
    reset       = 1'b1;
    pixelEnable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Continuous enable: replication, sync windows, blanking, frame wrap.
    repeat (2 * FRAME + 20) step(1'b1);

    // Enable with random gaps (including back-to-back enables).
    repeat (300) begin
      step(1'b1);
      repeat ($urandom_range(0, 3)) step(1'b0);
    end

    // Reset at hCount=5, vCount=2.
    guard = 0;
    while ((n % FRAME) != 33 && guard < 300) begin
      step(1'b1);
      guard++;
    end
    chk("reach_h5_v2", 32'(n % FRAME), 32'd33);
    reset_pulse();
    repeat (3) step(1'b1);
    repeat (FRAME + 30) begin
      step(1'b1);
      if ($urandom_range(0, 1) == 1) step(1'b0);
    end

    // Reset at a random raster position, then gapped running.
    repeat ($urandom_range(1, 200)) step(1'b1);
    reset_pulse();
    repeat (2 * FRAME) begin
      step(1'b1);
      repeat ($urandom_range(0, 2)) step(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
